// File: rtl/dino_pkg.sv
// Shared definitions for the dino game sequencer: state encoding, score width
// and default timing values.
package dino_pkg;

    typedef enum logic [1:0] {
        ST_ATTRACT = 2'd0,
        ST_START   = 2'd1,
        ST_RUN     = 2'd2,
        ST_CRASH   = 2'd3
    } game_state_t;

    localparam int SCORE_W             = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_HOLDOFF_FRAMES  = 30;
    localparam int DEF_BLINK_FRAMES    = 16;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-time filter and a one-cycle
// pulse on each debounced rising edge.
module btn_debounce
    import dino_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             btn_sync;

    assign btn_sync = sync_q[1];

    // The counter only runs while the synchronised input disagrees with the
    // debounced level, so any bounce back restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            press  <= 1'b0;
            if (btn_sync == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= btn_sync;
                press   <= btn_sync;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino game sequencer: attract/start/run/crash phases, jump requests,
// high-score tracking and game-over blink.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_ATTRACT | idle after reset, datapath held in reset, wait for press
// ST_START   | single-cycle datapath clear before a new game
// ST_RUN     | game running, presses become jumps, collision ends game
// ST_CRASH   | score frozen, blink game-over, restart after holdoff
module dino_game_ctrl
    import dino_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLDOFF_FRAMES  = DEF_HOLDOFF_FRAMES,
    parameter int BLINK_FRAMES    = DEF_BLINK_FRAMES
) (
    input  logic               clk,
    input  logic               sys_rst_n,
    input  logic               btn_raw,
    input  logic               frame_tick,
    input  logic               collision,
    input  logic [SCORE_W-1:0] score_in,
    output logic               game_rst,
    output logic               halt,
    output logic               jump,
    output logic [1:0]         state_out,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic               blink
);

    localparam int HOLD_W  = $clog2(HOLDOFF_FRAMES + 1);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLDOFF_FRAMES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic               press;
    game_state_t        state_q, state_d;
    logic               game_rst_d, halt_d, jump_d, new_high_d, blink_d;
    logic [SCORE_W-1:0] high_d;
    logic [HOLD_W-1:0]  holdoff_q, holdoff_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst_n  (sys_rst_n),
        .btn_raw(btn_raw),
        .press  (press)
    );

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_ATTRACT;
            game_rst    <= 1'b1;
            halt        <= 1'b1;
            jump        <= 1'b0;
            high_score  <= '0;
            new_high    <= 1'b0;
            blink       <= 1'b0;
            holdoff_q   <= '0;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            game_rst    <= game_rst_d;
            halt        <= halt_d;
            jump        <= jump_d;
            high_score  <= high_d;
            new_high    <= new_high_d;
            blink       <= blink_d;
            holdoff_q   <= holdoff_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        jump_d      = 1'b0;
        high_d      = high_score;
        new_high_d  = new_high;
        blink_d     = blink;
        holdoff_d   = holdoff_q;
        blink_cnt_d = blink_cnt_q;

        case (state_q)
            ST_ATTRACT: begin
                if (press) state_d = ST_START;
            end
            ST_START: begin
                state_d    = ST_RUN;
                new_high_d = 1'b0;
            end
            ST_RUN: begin
                // Collision takes priority: a simultaneous press is dropped.
                if (collision) begin
                    state_d     = ST_CRASH;
                    new_high_d  = (score_in > high_score);
                    if (score_in > high_score) high_d = score_in;
                    holdoff_d   = '0;
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                end else if (press) begin
                    jump_d = 1'b1;
                end
            end
            ST_CRASH: begin
                if (frame_tick) begin
                    if (holdoff_q != HOLD_MAX) holdoff_d = holdoff_q + 1'b1;
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = '0;
                        blink_d     = ~blink;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                if (press && (holdoff_q == HOLD_MAX)) begin
                    state_d = ST_START;
                    blink_d = 1'b0;
                end
            end
            default: state_d = ST_ATTRACT;
        endcase

        game_rst_d = (state_d == ST_ATTRACT) || (state_d == ST_START);
        halt_d     = (state_d != ST_RUN);
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed bench for dino_game_ctrl with short debounce/holdoff/blink settings.
module tb_dino_game_ctrl;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        btn_raw = 1'b0;
    logic        frame_tick = 1'b0;
    logic        collision = 1'b0;
    logic [15:0] score_in = 16'h0000;
    logic        game_rst, halt, jump, new_high, blink;
    logic [1:0]  state_out;
    logic [15:0] high_score;

    int n_checks = 0;
    int n_fail   = 0;

    dino_game_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .HOLDOFF_FRAMES (3),
        .BLINK_FRAMES   (2)
    ) dut (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .btn_raw   (btn_raw),
        .frame_tick(frame_tick),
        .collision (collision),
        .score_in  (score_in),
        .game_rst  (game_rst),
        .halt      (halt),
        .jump      (jump),
        .state_out (state_out),
        .high_score(high_score),
        .new_high  (new_high),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
    endtask

    // Drive the button to v for n cycles; jump must be high only on cycle jump_at.
    task automatic btn_run(input logic v, input int n, input int jump_at);
        btn_raw = v;
        for (int i = 1; i <= n; i++) begin
            tick();
            check_eq("jump", {15'd0, jump}, (i == jump_at) ? 16'd1 : 16'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_state"},    {14'd0, state_out}, 16'd0);
        check_eq({tag, "_game_rst"}, {15'd0, game_rst},  16'd1);
        check_eq({tag, "_halt"},     {15'd0, halt},      16'd1);
        check_eq({tag, "_jump"},     {15'd0, jump},      16'd0);
        check_eq({tag, "_high"},     high_score,         16'h0000);
        check_eq({tag, "_new_high"}, {15'd0, new_high},  16'd0);
        check_eq({tag, "_blink"},    {15'd0, blink},     16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset
        repeat (3) tick();
        check_reset_values("rst_held");
        sys_rst_n = 1'b1;
        tick();
        check_reset_values("rst_rel");

        // 2: a 2-cycle glitch is filtered, a steady press starts the game
        btn_raw = 1'b1;
        tick();
        tick();
        btn_raw = 1'b0;
        repeat (8) begin
            tick();
            check_eq("glitch_state", {14'd0, state_out}, 16'd0);
        end
        btn_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq("start_state", {14'd0, state_out},
                     (i < 7) ? 16'd0 : ((i == 7) ? 16'd1 : 16'd2));
            if (i == 7) begin
                check_eq("start_game_rst", {15'd0, game_rst}, 16'd1);
                check_eq("start_halt",     {15'd0, halt},     16'd1);
            end
            if (i == 8) begin
                check_eq("run_game_rst", {15'd0, game_rst}, 16'd0);
                check_eq("run_halt",     {15'd0, halt},     16'd0);
            end
        end

        // 3: jumps in RUN, one pulse per press
        btn_run(1'b0, 8, 0);
        btn_run(1'b1, 10, 7);
        btn_run(1'b0, 8, 0);
        btn_run(1'b1, 10, 7);
        btn_run(1'b0, 8, 0);

        // 4: first crash sets the high score
        score_in  = 16'h0123;
        collision = 1'b1;
        tick();
        collision = 1'b0;
        check_eq("crash1_state",    {14'd0, state_out}, 16'd3);
        check_eq("crash1_halt",     {15'd0, halt},      16'd1);
        check_eq("crash1_game_rst", {15'd0, game_rst},  16'd0);
        check_eq("crash1_high",     high_score,         16'h0123);
        check_eq("crash1_new_high", {15'd0, new_high},  16'd1);
        check_eq("crash1_blink",    {15'd0, blink},     16'd1);
        frame();
        check_eq("blink_f1", {15'd0, blink}, 16'd1);
        frame();
        check_eq("blink_f2", {15'd0, blink}, 16'd0);
        btn_run(1'b1, 8, 0);
        check_eq("holdoff_state", {14'd0, state_out}, 16'd3);
        btn_run(1'b0, 8, 0);
        frame();
        check_eq("blink_f3", {15'd0, blink}, 16'd0);
        frame();
        check_eq("blink_f4", {15'd0, blink}, 16'd1);
        btn_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq("restart_state", {14'd0, state_out},
                     (i < 7) ? 16'd3 : ((i == 7) ? 16'd1 : 16'd2));
            if (i == 7) begin
                check_eq("restart_blink",    {15'd0, blink},    16'd0);
                check_eq("restart_game_rst", {15'd0, game_rst}, 16'd1);
            end
            if (i == 8) begin
                check_eq("restart_halt",     {15'd0, halt},     16'd0);
                check_eq("restart_new_high", {15'd0, new_high}, 16'd0);
            end
        end

        // 5: lower score keeps the high score
        btn_run(1'b0, 8, 0);
        score_in  = 16'h0099;
        collision = 1'b1;
        tick();
        collision = 1'b0;
        check_eq("crash2_state",    {14'd0, state_out}, 16'd3);
        check_eq("crash2_high",     high_score,         16'h0123);
        check_eq("crash2_new_high", {15'd0, new_high},  16'd0);
        repeat (3) frame();
        btn_run(1'b1, 8, 0);
        check_eq("run2_state", {14'd0, state_out}, 16'd2);
        btn_run(1'b0, 8, 0);

        // 5b: collision and press on the same cycle, collision wins
        score_in = 16'h0150;
        btn_raw  = 1'b1;
        repeat (6) tick();
        collision = 1'b1;
        tick();
        collision = 1'b0;
        check_eq("tie_state",    {14'd0, state_out}, 16'd3);
        check_eq("tie_jump",     {15'd0, jump},      16'd0);
        check_eq("tie_high",     high_score,         16'h0150);
        check_eq("tie_new_high", {15'd0, new_high},  16'd1);
        tick();
        check_eq("tie_jump_next", {15'd0, jump}, 16'd0);

        // 6: asynchronous reset mid-RUN
        btn_run(1'b0, 8, 0);
        repeat (3) frame();
        btn_run(1'b1, 8, 0);
        check_eq("run3_state", {14'd0, state_out}, 16'd2);
        btn_raw = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (2) tick();
        sys_rst_n = 1'b1;
        repeat (4) begin
            tick();
            check_eq("post_rst_state", {14'd0, state_out}, 16'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
